serial_receiver: RTL

SERIAL_RECEIVER -- requirements
Module: serial_receiver

---
 rtl/serial_rx_pkg.sv | 26 ++
 rtl/serial_bit_counter.sv | 29 ++
 rtl/serial_receiver.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/serial_rx_pkg.sv
// Shared types and frame-format constants for the serial frame receiver.
// SERIAL_RX_PARITY_EN adds a trailing even-parity bit to every frame.
package serial_rx_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int LEN_W_DEF  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_HOLD
`ifdef SERIAL_RX_PARITY_EN
        , S_PARITY
`endif
    } state_t;

`ifdef SERIAL_RX_PARITY_EN
    localparam int     PARITY_BITS = 1;
    localparam state_t S_FRAME_END = S_PARITY;
`else
    localparam int     PARITY_BITS = 0;
    localparam state_t S_FRAME_END = S_HOLD;
`endif

endpackage

// File: rtl/serial_bit_counter.sv
// Frame bit counter: clear (optionally loading 1 when inc is also set),
// increment, and an equality match against a terminal value.
module serial_bit_counter
    import serial_rx_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [LEN_W-1:0] term,
    output logic [LEN_W-1:0] count,
    output logic             match
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= {{(LEN_W-1){1'b0}}, inc};
        end else if (inc) begin
            count <= count + LEN_W'(1);
        end
    end

    assign match = (count == term);

endmodule

// File: rtl/serial_receiver.sv
// Serial frame receiver: length field then payload, MSB first, with a
// valid/ready hold stage. SERIAL_RX_PARITY_EN enables the even-parity bit.
module serial_receiver
    import serial_rx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ser_in,
    input  logic              ser_valid,
    output logic [DATA_W-1:0] data_out,
    output logic [LEN_W-1:0]  data_len,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              overrun,
    output logic              parity_err
);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q;
    logic [DATA_W-1:0]  data_q;
    logic [LEN_W-1:0]   len_shift;
    logic [LEN_W-1:0]   cnt_term;
    logic [LEN_W-1:0]   cnt;
    logic               cnt_clr, cnt_inc, cnt_match;

    assign len_shift = {len_q[LEN_W-2:0], ser_in};
    // LEN counts the length field itself; PAYLOAD counts up to N-1.
    assign cnt_term  = (state_q == S_LEN) ? LEN_W'(LEN_W - 1) : len_q - LEN_W'(1);

    serial_bit_counter #(.LEN_W(LEN_W)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .term  (cnt_term),
        .count (cnt),
        .match (cnt_match)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ser_valid) begin
                    state_d = S_LEN;
                    cnt_clr = 1'b1;
                    cnt_inc = 1'b1;
                end
            end
            S_LEN: begin
                if (ser_valid) begin
                    if (cnt_match) begin
                        cnt_clr = 1'b1;
                        state_d = (len_shift != '0) ? S_PAYLOAD : S_FRAME_END;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            S_PAYLOAD: begin
                if (ser_valid) begin
                    if (cnt_match) begin
                        cnt_clr = 1'b1;
                        state_d = S_FRAME_END;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            S_PARITY: begin
                if (ser_valid) begin
                    cnt_clr = 1'b1;
                    state_d = S_HOLD;
                end
            end
`endif
            S_HOLD: begin
                if (data_ready) begin
                    cnt_clr = 1'b1;
                    if (ser_valid) begin
                        // Accepting and starting the next frame in one cycle.
                        state_d = S_LEN;
                        cnt_inc = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q  <= '0;
            data_q <= '0;
        end else begin
            case (state_q)
                S_IDLE:    if (ser_valid) len_q <= LEN_W'(ser_in);
                S_LEN:     if (ser_valid) len_q <= len_shift;
                S_PAYLOAD: if (ser_valid) data_q <= {data_q[DATA_W-2:0], ser_in};
                S_HOLD: begin
                    if (data_ready) begin
                        data_q <= '0;
                        len_q  <= ser_valid ? LEN_W'(ser_in) : '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_RX_PARITY_EN
    logic par_q, perr_q;

    // Running XOR over every frame bit; the parity bit closes it out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE:           if (ser_valid) par_q <= ser_in;
                S_LEN, S_PAYLOAD: if (ser_valid) par_q <= par_q ^ ser_in;
                S_PARITY:         if (ser_valid) perr_q <= par_q ^ ser_in;
                S_HOLD:           if (data_ready) par_q <= ser_valid & ser_in;
                default: ;
            endcase
        end
    end
`endif

    always_comb begin
        data_valid = (state_q == S_HOLD);
        overrun    = data_valid && ser_valid && !data_ready;
`ifdef SERIAL_RX_PARITY_EN
        parity_err = data_valid && perr_q;
`else
        parity_err = 1'b0;
`endif
    end

    assign data_out = data_q;
    assign data_len = len_q;

endmodule
